// File: rtl/vram_arb_pkg.sv
// Shared types and constants for the VRAM port arbiter: return-owner encoding,
// default widths and the streak-limit bound.
package vram_arb_pkg;

   localparam int ADDR_W_DEF       = 32;
   localparam int DATA_W_DEF       = 32;
   localparam int STREAK_W         = 4;
   localparam int MAX_STREAK_LIMIT = 15;

   typedef enum logic [1:0] {
      RET_NONE = 2'd0,
      RET_CPU  = 2'd1,
      RET_VGA  = 2'd2
   } ret_owner_t;

   // Out-of-range streak limits are pulled into 1..MAX_STREAK_LIMIT.
   function automatic logic [STREAK_W-1:0] clamp_streak(input int max_streak);
      if (max_streak < 1)                return STREAK_W'(1);
      if (max_streak > MAX_STREAK_LIMIT) return STREAK_W'(MAX_STREAK_LIMIT);
      return STREAK_W'(max_streak);
   endfunction

endpackage

// File: rtl/vram_port_arbiter_if.sv
// Bundle of the two requester ports and the RAM port seen by the arbiter.
interface vram_port_arbiter_if
   import vram_arb_pkg::*;
#(
   parameter int ADDR_W = ADDR_W_DEF,
   parameter int DATA_W = DATA_W_DEF
);

   // Handshake: a requester holds *_req with its address/data stable until it
   // sees *_gnt in the same cycle; a read granted in cycle t returns with
   // *_rvalid and *_rdata in cycle t+1; writes complete in the grant cycle.
   logic              cpu_req;
   logic              cpu_we;
   logic [ADDR_W-1:0] cpu_addr;
   logic [DATA_W-1:0] cpu_wdata;
   logic              cpu_gnt;
   logic              cpu_rvalid;
   logic [DATA_W-1:0] cpu_rdata;

   logic              vga_req;
   logic [ADDR_W-1:0] vga_addr;
   logic              vga_gnt;
   logic              vga_rvalid;
   logic [DATA_W-1:0] vga_rdata;

   logic              mem_en;
   logic              mem_we;
   logic [ADDR_W-1:0] mem_addr;
   logic [DATA_W-1:0] mem_wdata;
   logic [DATA_W-1:0] mem_rdata;

   modport slave (
      input  cpu_req, cpu_we, cpu_addr, cpu_wdata, vga_req, vga_addr, mem_rdata,
      output cpu_gnt, cpu_rvalid, cpu_rdata, vga_gnt, vga_rvalid, vga_rdata,
             mem_en, mem_we, mem_addr, mem_wdata
   );

   modport master (
      output cpu_req, cpu_we, cpu_addr, cpu_wdata, vga_req, vga_addr, mem_rdata,
      input  cpu_gnt, cpu_rvalid, cpu_rdata, vga_gnt, vga_rvalid, vga_rdata,
             mem_en, mem_we, mem_addr, mem_wdata
   );

endinterface

// File: rtl/vram_port_arbiter_streak.sv
// Saturating counter of consecutive VGA wins while the CPU waits; clear has
// priority over increment, otherwise the count holds.
module grant_streak_counter
   import vram_arb_pkg::*;
#(
   parameter logic [STREAK_W-1:0] MAX_COUNT = 4'd4
) (
   input  logic                clk,
   input  logic                reset,
   input  logic                clr,
   input  logic                inc,
   output logic [STREAK_W-1:0] count
);

   logic [STREAK_W-1:0] count_q;
   logic [STREAK_W-1:0] count_d;

   always_comb begin
      count_d = count_q;
      if (clr) begin
         count_d = '0;
      end else if (inc && (count_q < MAX_COUNT)) begin
         count_d = count_q + 1'b1;
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         count_q <= '0;
      end else begin
         count_q <= count_d;
      end
   end

   assign count = count_q;

endmodule

// File: rtl/vram_port_arbiter.sv
// Arbitrates the shared single-port RAM between the CPU load/store path and the
// real-time VGA pixel fetcher, with a VGA grant-streak cap to bound CPU wait.
module vram_port_arbiter
   import vram_arb_pkg::*;
#(
   parameter int ADDR_W         = ADDR_W_DEF,
   parameter int DATA_W         = DATA_W_DEF,
   parameter int MAX_VGA_STREAK = 4
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  enable,
   vram_port_arbiter_if.slave    bus,
   output logic [STREAK_W-1:0]   streak_dbg,
   output ret_owner_t            ret_dbg
);

   localparam logic [STREAK_W-1:0] MAX_STREAK = clamp_streak(MAX_VGA_STREAK);

   logic                cpu_wins_tie;
   logic                cpu_gnt;
   logic                vga_gnt;
   logic                streak_clr;
   logic                streak_inc;
   logic [STREAK_W-1:0] streak;
   logic [ADDR_W-1:0]   mem_addr_sel;
   ret_owner_t          ret_q;
   ret_owner_t          ret_d;
   logic [DATA_W-1:0]   cpu_rdata_q;
   logic [DATA_W-1:0]   cpu_rdata_d;
   logic [DATA_W-1:0]   vga_rdata_q;
   logic [DATA_W-1:0]   vga_rdata_d;

   // VGA wins ties unless it has already taken MAX_STREAK grants in a row.
   always_comb begin
      cpu_wins_tie = bus.cpu_req & (streak == MAX_STREAK);
      vga_gnt      = enable & bus.vga_req & ~cpu_wins_tie;
      cpu_gnt      = enable & bus.cpu_req & (~bus.vga_req | cpu_wins_tie);
      streak_clr   = enable & (cpu_gnt | ~bus.cpu_req);
      streak_inc   = vga_gnt & bus.cpu_req;
      mem_addr_sel = cpu_gnt ? bus.cpu_addr : bus.vga_addr;
   end

   grant_streak_counter #(
      .MAX_COUNT (MAX_STREAK)
   ) u_streak (
      .clk   (clk),
      .reset (reset),
      .clr   (streak_clr),
      .inc   (streak_inc),
      .count (streak)
   );

   always_comb begin
      ret_d = RET_NONE;
      if (cpu_gnt && !bus.cpu_we) begin
         ret_d = RET_CPU;
      end else if (vga_gnt) begin
         ret_d = RET_VGA;
      end
      cpu_rdata_d = (ret_q == RET_CPU) ? bus.mem_rdata : cpu_rdata_q;
      vga_rdata_d = (ret_q == RET_VGA) ? bus.mem_rdata : vga_rdata_q;
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         ret_q       <= RET_NONE;
         cpu_rdata_q <= '0;
         vga_rdata_q <= '0;
      end else begin
         ret_q       <= ret_d;
         cpu_rdata_q <= cpu_rdata_d;
         vga_rdata_q <= vga_rdata_d;
      end
   end

   // Grants and strobes are forced low while reset is held.
   assign bus.cpu_gnt    = cpu_gnt & reset;
   assign bus.vga_gnt    = vga_gnt & reset;
   assign bus.mem_en     = (cpu_gnt | vga_gnt) & reset;
   assign bus.mem_we     = cpu_gnt & bus.cpu_we & reset;
   assign bus.mem_addr   = mem_addr_sel;
   assign bus.mem_wdata  = bus.cpu_wdata;
   assign bus.cpu_rvalid = (ret_q == RET_CPU);
   assign bus.vga_rvalid = (ret_q == RET_VGA);
   assign bus.cpu_rdata  = cpu_rdata_d;
   assign bus.vga_rdata  = vga_rdata_d;

   assign streak_dbg = streak;
   assign ret_dbg    = ret_q;

endmodule

// File: tb/tb_vram_port_arbiter.sv
// Self-checking bench for vram_port_arbiter: directed scenarios plus random
// traffic against a rule-level reference model and a RAM behavioural model.
module tb_vram_port_arbiter;
   import vram_arb_pkg::*;

   localparam int AW   = 32;
   localparam int DW   = 32;
   localparam int MAXS = 4;

   // ---------------- clock / reset ----------------
   logic       clk      = 1'b0;
   logic       reset    = 1'b0;
   logic       enable   = 1'b0;
   logic       ram_fill = 1'b1;
   logic [3:0] streak_dbg;
   ret_owner_t ret_dbg;

   always #5 clk = ~clk;

   vram_port_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();

   vram_port_arbiter #(
      .ADDR_W         (AW),
      .DATA_W         (DW),
      .MAX_VGA_STREAK (MAXS)
   ) dut (
      .clk        (clk),
      .reset      (reset),
      .enable     (enable),
      .bus        (bus),
      .streak_dbg (streak_dbg),
      .ret_dbg    (ret_dbg)
   );

   function automatic logic [DW-1:0] ram_init(input int a);
      return (32'(a) * 32'h9E37_79B1) ^ 32'h5A5A_0000;
   endfunction

   // ---------------- RAM: synchronous read, 1-cycle latency ----------------
   logic [DW-1:0] ram [256];
   logic [DW-1:0] ram_q = '0;
   assign bus.mem_rdata = ram_q;

   always @(posedge clk) begin
      if (ram_fill) begin
         for (int i = 0; i < 256; i++) ram[i] <= ram_init(i);
      end else if (bus.mem_en) begin
         if (bus.mem_we) ram[bus.mem_addr[7:0]] <= bus.mem_wdata;
         else            ram_q <= ram[bus.mem_addr[7:0]];
      end
   end

   // ---------------- reference model / scoreboard ----------------
   logic [DW-1:0] shadow [256];
   logic [DW-1:0] cpu_exp_q[$];
   logic [DW-1:0] vga_exp_q[$];
   int            m_streak;
   bit            exp_cpu_rv, exp_vga_rv;
   logic [DW-1:0] last_cpu_rd, last_vga_rd;
   bit            last_cpu_gnt, last_vga_gnt;
   logic          obs_cpu_gnt, obs_vga_gnt;
   logic [3:0]    obs_streak;
   int            n_cmp = 0;
   int            n_err = 0;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
      end
   endtask

   task automatic model_reset();
      m_streak     = 0;
      exp_cpu_rv   = 0;
      exp_vga_rv   = 0;
      last_cpu_rd  = '0;
      last_vga_rd  = '0;
      last_cpu_gnt = 0;
      last_vga_gnt = 0;
      cpu_exp_q.delete();
      vga_exp_q.delete();
   endtask

   // Called at a negedge after inputs are applied; checks this cycle, advances
   // the model past the coming posedge, and returns at the next negedge.
   task automatic cycle();
      bit eg_cpu, eg_vga;
      #1;
      eg_cpu = 0;
      eg_vga = 0;
      if (reset && enable) begin
         if (bus.vga_req && bus.cpu_req) begin
            if (m_streak == MAXS) eg_cpu = 1;
            else                  eg_vga = 1;
         end else if (bus.vga_req) begin
            eg_vga = 1;
         end else if (bus.cpu_req) begin
            eg_cpu = 1;
         end
      end
      obs_cpu_gnt = bus.cpu_gnt;
      obs_vga_gnt = bus.vga_gnt;
      obs_streak  = streak_dbg;
      check("cpu_gnt", bus.cpu_gnt, eg_cpu);
      check("vga_gnt", bus.vga_gnt, eg_vga);
      check("mem_en",  bus.mem_en, eg_cpu | eg_vga);
      check("mem_we",  bus.mem_we, eg_cpu & bus.cpu_we);
      if (eg_cpu) begin
         check("mem_addr_cpu", bus.mem_addr, bus.cpu_addr);
         if (bus.cpu_we) check("mem_wdata", bus.mem_wdata, bus.cpu_wdata);
      end
      if (eg_vga) check("mem_addr_vga", bus.mem_addr, bus.vga_addr);
      check("streak", streak_dbg, 4'(m_streak));
      check("cpu_rvalid", bus.cpu_rvalid, exp_cpu_rv);
      check("vga_rvalid", bus.vga_rvalid, exp_vga_rv);
      if (exp_cpu_rv && cpu_exp_q.size() > 0) last_cpu_rd = cpu_exp_q.pop_front();
      if (exp_vga_rv && vga_exp_q.size() > 0) last_vga_rd = vga_exp_q.pop_front();
      check("cpu_rdata", bus.cpu_rdata, last_cpu_rd);
      check("vga_rdata", bus.vga_rdata, last_vga_rd);

      last_cpu_gnt = eg_cpu;
      last_vga_gnt = eg_vga;
      exp_cpu_rv   = eg_cpu && !bus.cpu_we;
      exp_vga_rv   = eg_vga;
      if (exp_cpu_rv) cpu_exp_q.push_back(shadow[bus.cpu_addr[7:0]]);
      if (eg_vga)     vga_exp_q.push_back(shadow[bus.vga_addr[7:0]]);
      if (eg_cpu && bus.cpu_we) shadow[bus.cpu_addr[7:0]] = bus.cpu_wdata;
      if (!reset) begin
         model_reset();
      end else if (enable) begin
         if (eg_cpu || !bus.cpu_req)          m_streak = 0;
         else if (eg_vga && m_streak < MAXS)  m_streak++;
      end
      @(negedge clk);
   endtask

   // ---------------- drivers ----------------
   task automatic set_cpu(input bit req, input bit we, input logic [AW-1:0] addr,
                          input logic [DW-1:0] wdata);
      bus.cpu_req   = req;
      bus.cpu_we    = we;
      bus.cpu_addr  = addr;
      bus.cpu_wdata = wdata;
   endtask

   task automatic set_vga(input bit req, input logic [AW-1:0] addr);
      bus.vga_req  = req;
      bus.vga_addr = addr;
   endtask

   // A requester only changes its request after a grant or while idle.
   task automatic drive_random();
      enable = ($urandom_range(0, 9) != 0);
      if (!bus.cpu_req || last_cpu_gnt)
         set_cpu($urandom_range(0, 99) < 60, $urandom_range(0, 1),
                 AW'($urandom_range(0, 63)), $urandom);
      if (!bus.vga_req || last_vga_gnt)
         set_vga($urandom_range(0, 99) < 70, AW'($urandom_range(0, 63)));
   endtask

   // ---------------- main sequence ----------------
   initial begin
      int nv;
      bit won;
      for (int i = 0; i < 256; i++) shadow[i] = ram_init(i);
      model_reset();
      set_cpu(0, 0, '0, '0);
      set_vga(0, '0);
      @(posedge clk);
      #1 ram_fill = 1'b0;
      @(negedge clk);

      // reset state
      set_cpu(1, 0, 32'h10, '0);
      set_vga(1, 32'h11);
      enable = 1'b1;
      check("reset_ret", ret_dbg, RET_NONE);
      cycle();
      set_cpu(0, 0, '0, '0);
      set_vga(0, '0);
      reset = 1'b1;
      cycle();

      // CPU read at 0x10
      set_cpu(1, 0, 32'h10, '0);
      cycle();
      check("t1_rvalid", bus.cpu_rvalid, 1'b1);
      check("t1_rdata", bus.cpu_rdata, ram_init(32'h10));
      set_cpu(0, 0, '0, '0);
      cycle();

      // CPU write then read back
      set_cpu(1, 1, 32'h20, 32'hDEAD_BEEF);
      cycle();
      set_cpu(0, 0, '0, '0);
      check("t2_no_rvalid", bus.cpu_rvalid, 1'b0);
      cycle();
      set_cpu(1, 0, 32'h20, '0);
      cycle();
      check("t2_readback", bus.cpu_rdata, 32'hDEAD_BEEF);
      set_cpu(0, 0, '0, '0);
      cycle();

      // both requesting continuously: V,V,V,V,C repeating
      set_cpu(1, 0, 32'h30, '0);
      set_vga(1, 32'h40);
      for (int i = 0; i < 10; i++) begin
         cycle();
         check("t3_seq", obs_cpu_gnt, (i % 5) == 4);
      end

      // enable low freezes arbitration and the streak
      cycle();
      cycle();
      enable = 1'b0;
      for (int i = 0; i < 3; i++) begin
         cycle();
         check("t4_nognt", obs_cpu_gnt | obs_vga_gnt, 1'b0);
         check("t4_streak", streak_dbg, 4'd2);
      end
      enable = 1'b1;
      for (int k = 0; k < 3; k++) begin
         cycle();
         check("t4_resume", obs_cpu_gnt, k == 2);
      end
      set_cpu(0, 0, '0, '0);
      set_vga(0, '0);
      cycle();

      // reset asserted just after a VGA read grant
      set_vga(1, 32'h05);
      #1 check("t5_gnt", bus.vga_gnt, 1'b1);
      @(posedge clk);
      #1 reset = 1'b0;
      model_reset();
      set_vga(0, '0);
      @(negedge clk);
      check("t5_no_rvalid", bus.vga_rvalid, 1'b0);
      set_cpu(1, 0, 32'h03, '0);
      set_vga(1, 32'h07);
      cycle();
      reset = 1'b1;
      cycle();
      check("t5_first_vga", obs_vga_gnt, 1'b1);
      check("t5_streak0", obs_streak, 4'd0);

      // dropping cpu_req clears the streak
      cycle();
      cycle();
      set_cpu(0, 0, '0, '0);
      cycle();
      set_cpu(1, 0, 32'h03, '0);
      nv  = 0;
      won = 0;
      for (int k = 0; k < 8; k++) begin
         if (!won) begin
            cycle();
            if (obs_cpu_gnt) won = 1;
            else if (obs_vga_gnt) nv++;
         end
      end
      check("t6_won", won, 1'b1);
      check("t6_wait", nv, 4);
      set_cpu(0, 0, '0, '0);
      set_vga(0, '0);
      cycle();

      // random traffic
      for (int i = 0; i < 2000; i++) begin
         drive_random();
         cycle();
      end
      enable = 1'b1;
      set_cpu(0, 0, '0, '0);
      set_vga(0, '0);
      for (int i = 0; i < 3; i++) cycle();
      check("drain_cpu", cpu_exp_q.size(), 0);
      check("drain_vga", vga_exp_q.size(), 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule

// File: doc/vram_port_arbiter.md
# vram_port_arbiter

Shares the CPU's single-port data/video RAM between two requesters: the CPU load/store path (`DataAdr`/`WriteData`/`MemWrite`/`ReadData`) and the VGA pixel fetcher that reads `pixel` at address `x`. The VGA fetcher has priority because it is real-time. A grant-streak limit prevents CPU starvation. The block sits between the CPU core, the pixel fetcher, and the RAM, in the `clk` domain; VGA-side clock crossing is handled upstream of `vga_*`.

## Interface
- `ADDR_W`, 32, address width of both requesters and the RAM.
- `DATA_W`, 32, data width.
- `MAX_VGA_STREAK`, 4, maximum consecutive VGA grants while the CPU is waiting; range 1..15.

- `clk` in 1: single clock, rising edge.
- `reset` in 1: asynchronous, active-low reset.
- `enable` in 1: when low, no new grants are issued; an in-flight read still returns.
- `cpu_req` in 1: CPU access request.
- `cpu_we` in 1: 1 = write, 0 = read.
- `cpu_addr` in `ADDR_W`: CPU address.
- `cpu_wdata` in `DATA_W`: CPU write data.
- `cpu_gnt` out 1: CPU access issued to the RAM this cycle.
- `cpu_rvalid` out 1: CPU read data valid.
- `cpu_rdata` out `DATA_W`: CPU read data.
- `vga_req` in 1: pixel read request.
- `vga_addr` in `ADDR_W`: pixel address.
- `vga_gnt` out 1: VGA read issued this cycle.
- `vga_rvalid` out 1: pixel data valid.
- `vga_rdata` out `DATA_W`: pixel word.
- `mem_en` out 1: RAM access strobe.
- `mem_we` out 1: RAM write enable.
- `mem_addr` out `ADDR_W`: RAM address.
- `mem_wdata` out `DATA_W`: RAM write data.
- `mem_rdata` in `DATA_W`: RAM read data, valid 1 cycle after a read strobe.

## Operation
**Request rules**
- A requester holds `*_req` and its address/data stable until it sees `*_gnt`.
- The arbiter never drops a held request.
- `*_gnt` is combinational from the current-cycle requests and registered state.

**Arbitration** (applies only when `enable`=1)
- Only `vga_req`: grant VGA.
- Only `cpu_req`: grant CPU.
- Both requesting: VGA wins, unless `streak` == `MAX_VGA_STREAK`, in which case the CPU wins.

**Streak counter**
- `streak` is 4 bits.
- Increments on each VGA grant while `cpu_req`=1, saturating at `MAX_VGA_STREAK`.
- Clears on any CPU grant, or on any cycle with `cpu_req`=0.

**RAM drive on a grant**
- `mem_en`=1.
- `mem_addr` and `mem_wdata` are muxed from the winner.
- `mem_we` = `cpu_we` for a CPU grant, and 0 for a VGA grant.
- With no grant, `mem_en`=`mem_we`=0.

**Return FSM** (`ret_q`, states `RET_NONE`, `RET_CPU`, `RET_VGA`)
- Next state is `RET_CPU` after a CPU read grant, `RET_VGA` after a VGA grant, and `RET_NONE` otherwise. CPU writes go to `RET_NONE`.
- `cpu_rvalid` = (`ret_q`==`RET_CPU`).
- `vga_rvalid` = (`ret_q`==`RET_VGA`).
- Both `rdata` outputs are registered copies of `mem_rdata`. The non-owner's `rdata` holds its last value.

**Other rules**
- A new grant may issue in the same cycle a previous read returns (full throughput of 1 access per cycle).
- `enable` low blocks grants and freezes `streak`. `ret_q` still advances to `RET_NONE` after the return.

## Timing
- Read latency: grant in cycle t, `*_rvalid` and data in cycle t+1. `rdata` is captured via `mem_rdata` at t+1 from the RAM's synchronous output; it is registered in `rdata` regs and visible at t+1 with `rvalid`.
- Write: completes in the grant cycle t; no `rvalid`.
- Reset (asynchronous, `reset`=0):
  - `ret_q`=`RET_NONE`, `streak`=0.
  - All `gnt`, `rvalid`, and `mem_en`/`mem_we` outputs = 0.
  - `rdata` outputs = 0.
- Reset mid-read: the in-flight return is discarded and no `rvalid` pulse is produced.
- Worst-case CPU wait with the VGA continuously requesting: `MAX_VGA_STREAK` cycles.
- `vga_rvalid` and `cpu_rvalid` are mutually exclusive, as are `vga_gnt` and `cpu_gnt`.

## Structure
- Package `vram_arb_pkg` holds:
  - enum `ret_owner_t` {`RET_NONE`, `RET_CPU`, `RET_VGA`};
  - the default width constants;
  - the `MAX_VGA_STREAK` bound check constant (15).
- One sub-module is natural: `grant_streak_counter` (saturating counter with clear/inc/hold).
- Grant muxing and the return FSM live in the top module.

## Test plan
- Reset released, `cpu_req`=1 read at `0x10`, no VGA: `cpu_gnt` in the same cycle, `mem_addr`=`0x10`; `cpu_rvalid`=1 next cycle with `cpu_rdata` = RAM[`0x10`].
- CPU write of `0xDEADBEEF` to `0x20`: `mem_we`=1 in the grant cycle; a later CPU read of `0x20` returns `0xDEADBEEF`, and no `rvalid` follows the write.
- Both requesting continuously, `MAX_VGA_STREAK`=4: grant sequence is V,V,V,V,C,V,V,V,V,C…; `vga_rvalid`/`cpu_rvalid` follow the grants exactly one cycle later.
- `enable`=0 for 3 cycles with both requesting: no grants and `streak` unchanged; after re-enable, arbitration resumes with the same count.
- Assert `reset`=0 in the cycle after a VGA grant: no `vga_rvalid`; all outputs are 0 during reset; after release, the first grant goes to VGA with `streak`=0.
- `cpu_req` dropped after 3 VGA grants, then reasserted: `streak` is cleared, and the CPU waits for a full 4 VGA grants before winning.
